// File: rtl/msp430_arb_pkg.sv
// Shared types and widths for the MSP430 memory backbone arbiter.
package msp430_arb_pkg;

   localparam int unsigned ADDR_W = 15;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned WE_W   = 2;

   typedef enum logic [1:0] {NONE, DBG, EU, DMA} owner_t;
   typedef enum logic       {IDLE, DMA_LOCK}      state_t;

endpackage

// File: rtl/msp430_arb_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear and increment together load 1.
module msp430_arb_sat_cnt #(
   parameter int unsigned MAX = 8,
   parameter int unsigned W   = $clog2(MAX + 1)
) (
   input  logic         mclk,
   input  logic         puc_rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] base;

   always_comb base = clr ? '0 : cnt;

   // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst)                        cnt <= '0;
      else if (inc && (base != W'(MAX)))  cnt <= base + W'(1);
      else                                cnt <= base;
   end

endmodule

// File: rtl/msp430_mem_arbiter.sv
// Arbitrates the single memory backbone between debug unit, execution unit and DMA.
import msp430_arb_pkg::*;

module msp430_mem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 8,
   parameter int unsigned MAX_BURST    = 4
) (
   input  logic              mclk,
   input  logic              puc_rst,
   input  logic              dbg_mem_en,
   input  logic [ADDR_W-1:0] dbg_mem_addr,
   input  logic [WE_W-1:0]   dbg_mem_wr,
   input  logic [DATA_W-1:0] dbg_mem_dout,
   output logic [DATA_W-1:0] dbg_mem_din,
   input  logic              eu_mb_en,
   input  logic [ADDR_W-1:0] eu_mab,
   input  logic [WE_W-1:0]   eu_mb_wr,
   input  logic [DATA_W-1:0] eu_mdb_out,
   output logic [DATA_W-1:0] eu_mdb_in,
   output logic              eu_wait,
   input  logic              dma_req,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [WE_W-1:0]   dma_wr,
   input  logic [DATA_W-1:0] dma_dout,
   input  logic              dma_lock,
   input  logic              dma_prio,
   output logic              dma_gnt,
   output logic [DATA_W-1:0] dma_din,
   output logic              dma_resp,
   output logic [ADDR_W-1:0] mab,
   output logic              mb_en,
   output logic [WE_W-1:0]   mb_wr,
   output logic [DATA_W-1:0] mdb_out,
   input  logic [DATA_W-1:0] mdb_in
);

   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
   localparam int unsigned BW = $clog2(MAX_BURST + 1);

   state_t        state, state_nxt;
   owner_t        owner, rd_owner;
   logic [SW-1:0] starve_cnt;
   logic [BW-1:0] beat_cnt;
   logic          last_beat;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      owner     = NONE;
      state_nxt = state;
      last_beat = (beat_cnt == BW'(MAX_BURST - 1));

      // Grants are masked during reset so outputs show reset values while inputs are still active.
      if (puc_rst)                owner = NONE;
      else if (dbg_mem_en)        owner = DBG;
      else if (state == DMA_LOCK) owner = dma_req ? DMA : NONE;
      else if (dma_req && (dma_prio || (starve_cnt == SW'(STARVE_LIMIT)) || !eu_mb_en))
                                  owner = DMA;
      else if (eu_mb_en)          owner = EU;

      case (state)
         IDLE:     if ((owner == DMA) && dma_lock && (MAX_BURST > 1)) state_nxt = DMA_LOCK;
         DMA_LOCK: if (!dma_req || !dma_lock || dbg_mem_en || last_beat) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst) state <= IDLE;
      else         state <= state_nxt;
   end

   msp430_arb_sat_cnt #(.MAX(STARVE_LIMIT)) u_starve_cnt (
      .mclk    (mclk),
      .puc_rst (puc_rst),
      .clr     (!dma_req || dma_gnt),
      .inc     (dma_req && !dma_gnt),
      .cnt     (starve_cnt)
   );

   // Entering a burst loads 1; any cycle that ends or stays outside a burst clears it.
   msp430_arb_sat_cnt #(.MAX(MAX_BURST)) u_beat_cnt (
      .mclk    (mclk),
      .puc_rst (puc_rst),
      .clr     ((state == IDLE) || (state_nxt == IDLE)),
      .inc     ((owner == DMA) && (state_nxt == DMA_LOCK)),
      .cnt     (beat_cnt)
   );

   always_comb begin
      mab     = '0;
      mb_wr   = '0;
      mdb_out = '0;
      case (owner)
         DBG:     begin mab = dbg_mem_addr; mb_wr = dbg_mem_wr; mdb_out = dbg_mem_dout; end
         EU:      begin mab = eu_mab;       mb_wr = eu_mb_wr;   mdb_out = eu_mdb_out;   end
         DMA:     begin mab = dma_addr;     mb_wr = dma_wr;     mdb_out = dma_dout;     end
         default: ;
      endcase
   end

   assign mb_en   = (owner != NONE);
   assign dma_gnt = (owner == DMA);
   assign eu_wait = eu_mb_en && (owner != EU);

   always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst)                    rd_owner <= NONE;
      else if (mb_en && (mb_wr == '0)) rd_owner <= owner;
      else                            rd_owner <= NONE;
   end

   assign dma_resp    = (rd_owner == DMA);
   assign dma_din     = mdb_in;
   assign eu_mdb_in   = mdb_in;
   assign dbg_mem_din = mdb_in;

endmodule

// File: tb/tb_msp430_mem_arbiter.sv
// Directed bench for msp430_mem_arbiter: starvation, locked bursts, debug preemption, read return, reset.
module tb_msp430_mem_arbiter;

   logic        mclk = 1'b0;
   logic        puc_rst;
   logic        dbg_mem_en;
   logic [14:0] dbg_mem_addr;
   logic [1:0]  dbg_mem_wr;
   logic [15:0] dbg_mem_dout;
   logic [15:0] dbg_mem_din;
   logic        eu_mb_en;
   logic [14:0] eu_mab;
   logic [1:0]  eu_mb_wr;
   logic [15:0] eu_mdb_out;
   logic [15:0] eu_mdb_in;
   logic        eu_wait;
   logic        dma_req;
   logic [14:0] dma_addr;
   logic [1:0]  dma_wr;
   logic [15:0] dma_dout;
   logic        dma_lock;
   logic        dma_prio;
   logic        dma_gnt;
   logic [15:0] dma_din;
   logic        dma_resp;
   logic [14:0] mab;
   logic        mb_en;
   logic [1:0]  mb_wr;
   logic [15:0] mdb_out;
   logic [15:0] mdb_in;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 mclk = ~mclk;

   msp430_mem_arbiter #(.STARVE_LIMIT(8), .MAX_BURST(4)) dut (
      .mclk         (mclk),
      .puc_rst      (puc_rst),
      .dbg_mem_en   (dbg_mem_en),
      .dbg_mem_addr (dbg_mem_addr),
      .dbg_mem_wr   (dbg_mem_wr),
      .dbg_mem_dout (dbg_mem_dout),
      .dbg_mem_din  (dbg_mem_din),
      .eu_mb_en     (eu_mb_en),
      .eu_mab       (eu_mab),
      .eu_mb_wr     (eu_mb_wr),
      .eu_mdb_out   (eu_mdb_out),
      .eu_mdb_in    (eu_mdb_in),
      .eu_wait      (eu_wait),
      .dma_req      (dma_req),
      .dma_addr     (dma_addr),
      .dma_wr       (dma_wr),
      .dma_dout     (dma_dout),
      .dma_lock     (dma_lock),
      .dma_prio     (dma_prio),
      .dma_gnt      (dma_gnt),
      .dma_din      (dma_din),
      .dma_resp     (dma_resp),
      .mab          (mab),
      .mb_en        (mb_en),
      .mb_wr        (mb_wr),
      .mdb_out      (mdb_out),
      .mdb_in       (mdb_in)
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic cyc;
      @(posedge mclk);
      #1;
   endtask

   task automatic clear_inputs;
      dbg_mem_en = 1'b0; dbg_mem_addr = '0; dbg_mem_wr = '0; dbg_mem_dout = '0;
      eu_mb_en   = 1'b0; eu_mab       = '0; eu_mb_wr   = '0; eu_mdb_out   = '0;
      dma_req    = 1'b0; dma_addr     = '0; dma_wr     = '0; dma_dout     = '0;
      dma_lock   = 1'b0; dma_prio     = 1'b0; mdb_in   = '0;
   endtask

   initial begin
      // Reset with requests active: no grants may leak through.
      clear_inputs;
      puc_rst  = 1'b1;
      eu_mb_en = 1'b1;
      dma_req  = 1'b1;
      dma_prio = 1'b1;
      #2;
      check("rst_dma_gnt", dma_gnt, 0);
      check("rst_mb_en", mb_en, 0);
      check("rst_eu_wait", eu_wait, 1);
      check("rst_dma_resp", dma_resp, 0);
      check("rst_mab", mab, 0);

      // Starvation: EU wins 8 cycles, DMA forced through on cycle 9.
      cyc;
      puc_rst = 1'b0;
      clear_inputs;
      eu_mb_en = 1'b1; eu_mab = 15'h0200;
      dma_req  = 1'b1; dma_addr = 15'h0100;
      for (int i = 1; i <= 8; i++) begin
         #4;
         check("starve_eu_wait", eu_wait, 0);
         check("starve_dma_gnt", dma_gnt, 0);
         check("starve_mab", mab, 15'h0200);
         cyc;
      end
      #4;
      check("starve9_dma_gnt", dma_gnt, 1);
      check("starve9_eu_wait", eu_wait, 1);
      check("starve9_mab", mab, 15'h0100);
      cyc;
      #4;
      check("starve10_dma_resp", dma_resp, 1);
      check("starve10_eu_wait", eu_wait, 0);
      check("starve10_dma_gnt", dma_gnt, 0);
      cyc;
      clear_inputs;
      cyc;

      // Locked burst of MAX_BURST beats, then EU on re-arbitration.
      dma_req = 1'b1; dma_prio = 1'b1; dma_lock = 1'b1;
      dma_wr  = 2'b11; dma_dout = 16'hBEEF; dma_addr = 15'h0300;
      eu_mb_en = 1'b1; eu_mab = 15'h0200;
      #4;
      check("burst1_dma_gnt", dma_gnt, 1);
      check("burst1_eu_wait", eu_wait, 1);
      cyc;
      dma_prio = 1'b0;
      for (int b = 2; b <= 4; b++) begin
         dma_addr = 15'h0300 + 15'(b - 1);
         #4;
         check("burst_dma_gnt", dma_gnt, 1);
         check("burst_eu_wait", eu_wait, 1);
         check("burst_mab", mab, 15'h0300 + 15'(b - 1));
         cyc;
      end
      #4;
      check("burst_end_dma_gnt", dma_gnt, 0);
      check("burst_end_eu_wait", eu_wait, 0);
      check("burst_end_mab", mab, 15'h0200);
      check("burst_write_no_resp", dma_resp, 0);
      cyc;
      clear_inputs;
      cyc;

      // Debug preempts beat 2 of a locked burst.
      dma_req = 1'b1; dma_prio = 1'b1; dma_lock = 1'b1; dma_addr = 15'h0400;
      #4;
      check("dbg_beat1_dma_gnt", dma_gnt, 1);
      cyc;
      dbg_mem_en = 1'b1; dbg_mem_addr = 15'h0555;
      #4;
      check("dbg_beat2_dma_gnt", dma_gnt, 0);
      check("dbg_beat2_mab", mab, 15'h0555);
      check("dbg_beat2_mb_en", mb_en, 1);
      check("dbg_beat2_dma_resp", dma_resp, 1);
      cyc;
      dbg_mem_en = 1'b0; dma_prio = 1'b0;
      eu_mb_en = 1'b1; eu_mab = 15'h0222; mdb_in = 16'h7E57;
      #4;
      check("dbg_after_eu_wait", eu_wait, 0);
      check("dbg_after_dma_gnt", dma_gnt, 0);
      check("dbg_after_dma_resp", dma_resp, 0);
      check("dbg_din", dbg_mem_din, 16'h7E57);
      cyc;
      dma_prio = 1'b1;
      #4;
      check("dbg_rearb_dma_gnt", dma_gnt, 1);
      check("dbg_rearb_eu_wait", eu_wait, 1);
      cyc;
      clear_inputs;
      cyc;

      // DMA read of 0x0100 with data returned the following cycle.
      dma_req = 1'b1; dma_addr = 15'h0100;
      #4;
      check("rd_dma_gnt", dma_gnt, 1);
      check("rd_mab", mab, 15'h0100);
      check("rd_mb_wr", mb_wr, 0);
      check("rd_resp_early", dma_resp, 0);
      cyc;
      dma_req = 1'b0; mdb_in = 16'hA5C3;
      #4;
      check("rd_dma_resp", dma_resp, 1);
      check("rd_dma_din", dma_din, 16'hA5C3);
      check("rd_mb_en_idle", mb_en, 0);
      cyc;
      #4;
      check("rd_resp_once", dma_resp, 0);
      cyc;

      // DMA low-byte write.
      dma_req = 1'b1; dma_wr = 2'b01; dma_dout = 16'h1234; dma_addr = 15'h0101;
      #4;
      check("wr_dma_gnt", dma_gnt, 1);
      check("wr_mb_wr", mb_wr, 2'b01);
      check("wr_mdb_out", mdb_out, 16'h1234);
      cyc;
      dma_req = 1'b0; dma_wr = 2'b00;
      #4;
      check("wr_no_resp", dma_resp, 0);
      cyc;

      // Reset in the middle of a locked read burst.
      dma_req = 1'b1; dma_prio = 1'b1; dma_lock = 1'b1; dma_addr = 15'h0600;
      eu_mb_en = 1'b1; eu_mab = 15'h0333;
      #4;
      check("rstb_beat1", dma_gnt, 1);
      cyc;
      #4;
      check("rstb_beat2", dma_gnt, 1);
      cyc;
      puc_rst = 1'b1;
      #1;
      check("rstb_dma_gnt", dma_gnt, 0);
      check("rstb_mb_en", mb_en, 0);
      check("rstb_dma_resp", dma_resp, 0);
      check("rstb_eu_wait", eu_wait, 1);
      check("rstb_mab", mab, 0);
      cyc;
      puc_rst = 1'b0;
      dma_req = 1'b0; eu_mb_en = 1'b0;
      #4;
      check("rstb_release_resp", dma_resp, 0);
      cyc;
      dma_req = 1'b1; dma_prio = 1'b0; dma_lock = 1'b1; eu_mb_en = 1'b1;
      #4;
      check("rstb_idle_dma_gnt", dma_gnt, 0);
      check("rstb_idle_eu_wait", eu_wait, 0);
      check("rstb_idle_resp", dma_resp, 0);
      cyc;
      clear_inputs;
      cyc;

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
